// File: rtl/ddr_tip_pkg.sv
// Shared DDR PHY training IP definitions: DLL update FSM state encodings and DFI constants.
package ddr_tip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PENDING  = 3'd1,
    ST_CTRL_UPD = 3'd2,
    ST_CTRL_END = 3'd3,
    ST_PHY_REQ  = 3'd4,
    ST_PHY_UPD  = 3'd5,
    ST_PHY_END  = 3'd6
  } dll_upd_state_e;

  localparam logic [1:0] DFI_PHYUPD_TYPE0 = 2'b00;

endpackage

// File: rtl/dll_diff_sync.sv
// Synchronises the asynchronous DLL drift flag and qualifies it once it has been held
// high for DEBOUNCE consecutive synchronised cycles; dbg_rise marks the qualifying cycle.
module dll_diff_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic SCLK,
  input  logic reset,
  input  logic dll_dly_diff,
  output logic dbg_diff,
  output logic dbg_rise
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [DB_W-1:0]        db_cnt;
  logic                   synced;

  assign synced = sync_p[SYNC_STAGES-1];

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      sync_p   <= '0;
      db_cnt   <= '0;
      dbg_diff <= 1'b0;
      dbg_rise <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], dll_dly_diff};
      if (!synced) begin
        db_cnt   <= '0;
        dbg_diff <= 1'b0;
        dbg_rise <= 1'b0;
      end else begin
        // Counter saturates at DEBOUNCE so the rise fires only once per high run
        if (db_cnt != DB_W'(DEBOUNCE))
          db_cnt <= db_cnt + DB_W'(1);
        dbg_rise <= (db_cnt == DB_W'(DEBOUNCE - 1));
        if (db_cnt == DB_W'(DEBOUNCE - 1))
          dbg_diff <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dll_code_update_ctrl.sv
// Schedules DLL code updates inside DFI update windows: rides a controller update when one
// arrives, otherwise requests a PHY-initiated update after PHYUPD_TIMEOUT cycles pending.
module dll_code_update_ctrl
  import ddr_tip_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE       = 4,
  parameter int UPD_CYCLES     = 8,
  parameter int PHYUPD_TIMEOUT = 1024
) (
  input  logic        SCLK,
  input  logic        reset,
  input  logic        dll_dly_diff,
  input  logic        dfi_ctrlupd_req,
  output logic        dfi_ctrlupd_ack,
  output logic        dfi_phyupd_req,
  output logic [1:0]  dfi_phyupd_type,
  input  logic        dfi_phyupd_ack,
  output logic        code_update,
  output logic        update_pending,
  output logic [15:0] update_count
);

  localparam int TMR_W = $clog2(PHYUPD_TIMEOUT);
  localparam int CNT_W = $clog2(UPD_CYCLES);

  dll_upd_state_e   state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_d, preq_d, cu_d;
  logic             pending_q;
  logic             dbg_diff, dbg_rise, drift_set;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  dll_diff_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE)
  ) u_diff_sync (
    .SCLK        (SCLK),
    .reset       (reset),
    .dll_dly_diff(dll_dly_diff),
    .dbg_diff    (dbg_diff),
    .dbg_rise    (dbg_rise)
  );

  assign drift_set       = dbg_rise & dbg_diff;
  assign dfi_phyupd_type = DFI_PHYUPD_TYPE0;
  assign update_pending  = pending_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    preq_d  = 1'b0;
    cu_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d = ST_PENDING;
          timer_d = '0;
        end
      end
      ST_PENDING: begin
        // A controller window wins over a timeout landing on the same cycle
        if (dfi_ctrlupd_req) begin
          state_d = ST_CTRL_UPD;
          ack_d   = 1'b1;
          cu_d    = 1'b1;
          cnt_d   = '0;
        end else if (timer_q == TMR_W'(PHYUPD_TIMEOUT - 1)) begin
          state_d = ST_PHY_REQ;
          preq_d  = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_CTRL_UPD: begin
        if (cnt_q == CNT_W'(UPD_CYCLES - 1) || !dfi_ctrlupd_req) begin
          state_d = ST_CTRL_END;
        end else begin
          ack_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CTRL_END: begin
        if (!dfi_ctrlupd_req) state_d = ST_IDLE;
      end
      ST_PHY_REQ: begin
        preq_d = 1'b1;
        if (dfi_phyupd_ack) begin
          state_d = ST_PHY_UPD;
          cu_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_PHY_UPD: begin
        if (cnt_q == CNT_W'(UPD_CYCLES - 1)) begin
          state_d = ST_PHY_END;
        end else begin
          preq_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      ST_PHY_END: begin
        if (!dfi_phyupd_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      cnt_q           <= '0;
      dfi_ctrlupd_ack <= 1'b0;
      dfi_phyupd_req  <= 1'b0;
      code_update     <= 1'b0;
      pending_q       <= 1'b0;
      update_count    <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      cnt_q           <= cnt_d;
      dfi_ctrlupd_ack <= ack_d;
      dfi_phyupd_req  <= preq_d;
      code_update     <= cu_d;
      // A drift qualifying in the same cycle as the update must survive the clear
      pending_q       <= drift_set | (pending_q & ~cu_d);
      if (cu_d)
        update_count <= sat_inc16(update_count);
    end
  end

endmodule

// File: tb/tb_dll_code_update_ctrl.sv
// Directed/randomised bench for dll_code_update_ctrl: each scenario lists input and expected
// output activity as slot intervals derived from the update rules, then checks every cycle.
module tb_dll_code_update_ctrl;

  localparam int SYNC_STAGES    = 2;
  localparam int DEBOUNCE       = 4;
  localparam int UPD_CYCLES     = 8;
  localparam int PHYUPD_TIMEOUT = 1024;
  // Diff set in slot n shows up as update_pending in slot n+LATP
  localparam int LATP = SYNC_STAGES + DEBOUNCE + 1;

  localparam int K_DIFF = 0, K_CREQ = 1, K_PACK = 2, K_ACK = 3, K_PREQ = 4, K_CU = 5, K_PEND = 6;

  typedef struct {
    int lo;
    int hi;
  } win_t;

  logic        SCLK = 1'b0;
  logic        reset = 1'b0;
  logic        dll_dly_diff = 1'b0;
  logic        dfi_ctrlupd_req = 1'b0;
  logic        dfi_phyupd_ack = 1'b0;
  logic        dfi_ctrlupd_ack;
  logic        dfi_phyupd_req;
  logic [1:0]  dfi_phyupd_type;
  logic        code_update;
  logic        update_pending;
  logic [15:0] update_count;

  win_t wq [7][$];
  int   cyc = 0;
  int   cnt_base = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  dll_code_update_ctrl #(
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE      (DEBOUNCE),
    .UPD_CYCLES    (UPD_CYCLES),
    .PHYUPD_TIMEOUT(PHYUPD_TIMEOUT)
  ) dut (
    .SCLK           (SCLK),
    .reset          (reset),
    .dll_dly_diff   (dll_dly_diff),
    .dfi_ctrlupd_req(dfi_ctrlupd_req),
    .dfi_ctrlupd_ack(dfi_ctrlupd_ack),
    .dfi_phyupd_req (dfi_phyupd_req),
    .dfi_phyupd_type(dfi_phyupd_type),
    .dfi_phyupd_ack (dfi_phyupd_ack),
    .code_update    (code_update),
    .update_pending (update_pending),
    .update_count   (update_count)
  );

  initial forever #5 SCLK = ~SCLK;

  task automatic step();
    @(posedge SCLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s slot %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic hit(input int k, input int t);
    for (int i = 0; i < wq[k].size(); i++)
      if (t >= wq[k][i].lo && t <= wq[k][i].hi) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int cu_upto(input int t);
    int n = 0;
    for (int i = 0; i < wq[K_CU].size(); i++)
      if (wq[K_CU][i].lo <= t)
        n += ((t < wq[K_CU][i].hi) ? t : wq[K_CU][i].hi) - wq[K_CU][i].lo + 1;
    return n;
  endfunction

  task automatic add(input int k, input int lo, input int hi);
    win_t w;
    w.lo = lo;
    w.hi = hi;
    wq[k].push_back(w);
  endtask

  task automatic new_sc();
    cnt_base = cnt_base + cu_upto(cyc);
    for (int k = 0; k < 7; k++) wq[k].delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 16'(dfi_ctrlupd_ack), 16'd0);
    chk({tag, "_preq"}, 16'(dfi_phyupd_req), 16'd0);
    chk({tag, "_cu"}, 16'(code_update), 16'd0);
    chk({tag, "_pend"}, 16'(update_pending), 16'd0);
    chk({tag, "_count"}, update_count, 16'd0);
    chk({tag, "_type"}, 16'(dfi_phyupd_type), 16'd0);
  endtask

  // Check outputs of the current slot, then drive inputs sampled at the next edge
  task automatic run_until(input int tend);
    while (cyc < tend) begin
      chk("ctrlupd_ack", 16'(dfi_ctrlupd_ack), 16'(hit(K_ACK, cyc)));
      chk("phyupd_req", 16'(dfi_phyupd_req), 16'(hit(K_PREQ, cyc)));
      chk("code_update", 16'(code_update), 16'(hit(K_CU, cyc)));
      chk("update_pending", 16'(update_pending), 16'(hit(K_PEND, cyc)));
      chk("update_count", update_count, 16'(cnt_base + cu_upto(cyc)));
      chk("phyupd_type", 16'(dfi_phyupd_type), 16'd0);
      dll_dly_diff    = hit(K_DIFF, cyc);
      dfi_ctrlupd_req = hit(K_CREQ, cyc);
      dfi_phyupd_ack  = hit(K_PACK, cyc);
      step();
    end
  endtask

  // Drift of length len, then a controller request starting roff slots after PENDING entry
  task automatic sc_ctrl(input int len, input int roff, input int lr_extra);
    int b, n, p, r, s0, lr, a, e, tend;
    new_sc();
    b  = cyc;
    n  = b + 2;
    p  = n + LATP;
    r  = p + 1 + roff;
    s0 = (r > p + 1) ? r : p + 1;
    lr = s0 - r + 1 + lr_extra;
    a  = s0 + 1;
    e  = r + lr - a;
    if (e > UPD_CYCLES - 1) e = UPD_CYCLES - 1;
    add(K_DIFF, n, n + len - 1);
    add(K_CREQ, r, r + lr - 1);
    add(K_ACK, a, a + e);
    add(K_CU, a, a);
    add(K_PEND, p, a - 1);
    tend = r + lr;
    if (a + UPD_CYCLES > tend) tend = a + UPD_CYCLES;
    if (n + len > tend) tend = n + len;
    run_until(tend + 4);
  endtask

  // Drift with no controller request: PHY-initiated update, grant qd slots after the request
  task automatic sc_phy(input int len, input int qd, input int h, input bit do_rst);
    int b, n, p, pr, q;
    new_sc();
    b  = cyc;
    n  = b + 2;
    p  = n + LATP;
    pr = p + 1 + PHYUPD_TIMEOUT;
    q  = pr + qd;
    add(K_DIFF, n, n + len - 1);
    add(K_PACK, q, q + UPD_CYCLES + 1 + h);
    add(K_PREQ, pr, q + UPD_CYCLES);
    add(K_CU, q + 1, q + 1);
    add(K_PEND, p, q);
    if (!do_rst) begin
      run_until(q + UPD_CYCLES + h + 6);
    end else begin
      run_until(q + 3);
      chk("preq_before_reset", 16'(dfi_phyupd_req), 16'd1);
      chk("count_before_reset", update_count, 16'(cnt_base + 1));
      dll_dly_diff    = 1'b0;
      dfi_ctrlupd_req = 1'b0;
      dfi_phyupd_ack  = 1'b0;
      reset = 1'b1;
      #1;
      chk_all_zero("mid_reset");
      step();
      step();
      reset = 1'b0;
      for (int k = 0; k < 7; k++) wq[k].delete();
      cnt_base = 0;
      run_until(cyc + 10);
    end
  endtask

  initial begin
    #2;
    reset = 1'b1;
    step();
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    run_until(cyc + 5);

    // Short drift below the debounce length, plus a controller request with nothing pending
    begin
      int b, l;
      new_sc();
      b = cyc;
      l = 1 + int'($urandom % 3);
      add(K_DIFF, b + 2, b + 1 + l);
      add(K_CREQ, b + 10, b + 15);
      run_until(b + 30);
    end

    // Controller-driven update: drift 10 cycles, request 20 cycles after drift, 12 long
    sc_ctrl(10, 12, 11);
    for (int i = 0; i < 3; i++)
      sc_ctrl(4 + int'($urandom % 8), int'($urandom % 27) - 6, int'($urandom % 12));

    // PHY-initiated update, grant 5 cycles after the request, then a random grant delay
    sc_phy(6, 5, 2, 1'b0);
    sc_phy(4 + int'($urandom % 5), int'($urandom % 10), int'($urandom % 6), 1'b0);

    // Controller request arriving on the timeout cycle takes the controller path
    sc_ctrl(5, PHYUPD_TIMEOUT - 1, 9);

    // New drift qualifies in the middle of a controller update
    begin
      int b;
      new_sc();
      b = cyc;
      add(K_DIFF, b + 2, b + 6);
      add(K_DIFF, b + 9, b + 14);
      add(K_CREQ, b + 12, b + 23);
      add(K_CREQ, b + 30, b + 39);
      add(K_ACK, b + 13, b + 20);
      add(K_ACK, b + 31, b + 38);
      add(K_CU, b + 13, b + 13);
      add(K_CU, b + 31, b + 31);
      add(K_PEND, b + 9, b + 12);
      add(K_PEND, b + 16, b + 30);
      run_until(b + 45);
    end

    // New drift qualifies on the very cycle the update is applied
    begin
      int b;
      new_sc();
      b = cyc;
      add(K_DIFF, b + 2, b + 5);
      add(K_DIFF, b + 7, b + 12);
      add(K_CREQ, b + 13, b + 22);
      add(K_CREQ, b + 28, b + 37);
      add(K_ACK, b + 14, b + 21);
      add(K_ACK, b + 29, b + 36);
      add(K_CU, b + 14, b + 14);
      add(K_CU, b + 29, b + 29);
      add(K_PEND, b + 9, b + 28);
      run_until(b + 43);
    end

    // Reset in the middle of a PHY update window, then normal operation from zero
    sc_phy(5, 4, 3, 1'b1);
    sc_ctrl(5, 3, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
